// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus interconnect blocks: arbitration modes
// and the channel-index width helper.
package cpu_bus_pkg;

    localparam logic PRIO_RR    = 1'b0;
    localparam logic PRIO_FIXED = 1'b1;

    // An index into a 1- or 2-entry table still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: round-robin from ptr, or fixed priority with
// channel 0 highest. Produces a one-hot grant plus its encoded index.
module rr_arbiter
    import cpu_bus_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int CH_W = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    input  logic            mode,
    output logic [N_CH-1:0] gnt,
    output logic [CH_W-1:0] gnt_idx,
    output logic            any
);

    int               start;
    int               cand;
    logic [CH_W-1:0]  cand_idx;

    // Scan N_CH slots from the start channel, wrapping past N_CH-1 to 0;
    // the first requester seen wins. Fixed mode simply starts at 0.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        start    = (mode == PRIO_FIXED) ? 0 : int'(ptr);
        for (int off = 0; off < N_CH; off++) begin
            cand = start + off;
            if (cand >= N_CH) cand = cand - N_CH;
            cand_idx = CH_W'(cand);
            if (!any && req[cand_idx]) begin
                any     = 1'b1;
                gnt_idx = cand_idx;
            end
        end
        if (any) gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/rr_bus_mux.sv
// Registered N-input bus multiplexer: arbitrates one source per transfer and
// presents it on a single registered output port.
module rr_bus_mux
    import cpu_bus_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int N_CH  = 4,
    localparam int CH_W  = clog2_min1(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  prio_mode,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]       out_ch,
    input  logic                  out_ready
);

    // Handshake: a word moves on any rising edge where valid && ready are both
    // high on that link; a source holds valid/data steady until it sees ready,
    // and ready never depends on a word being dropped.
    logic              load_en;
    logic              take;
    logic [N_CH-1:0]   gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic              any;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   ptr_next;
    logic [WIDTH-1:0]  sel_data;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .mode    (prio_mode),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign load_en  = !out_valid || out_ready;
    // Gate with rst_n so no source believes it was accepted during reset.
    assign in_ready = (load_en && rst_n) ? gnt : '0;
    assign take     = load_en && any;
    assign sel_data = in_data[gnt_idx*WIDTH +: WIDTH];
    assign ptr_next = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= gnt_idx;
            rr_ptr    <= ptr_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
